// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, reset PC and the fetch-stage state type.
package cpu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    StIdle,   // no fetch outstanding
    StWait,   // fetch issued, waiting on memory
    StValid   // instruction held for the control FSM
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control-FSM handshake, jump controls and the instruction memory read port.
//   master: control FSM / environment side (drives requests, acks, jumps and memory read data)
//   slave : fetch unit side (drives memory address, instruction, valid, pc, busy, retire count)
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
);

  logic              fetch_req;
  logic              instr_ack;
  logic              pc_ld;
  logic              pc_rel;
  logic [ADDR_W-1:0] pc_target;
  logic [7:0]        disp;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic [15:0]       instr_count;

  modport master (
    output fetch_req, instr_ack, pc_ld, pc_rel, pc_target, disp, mem_rdata,
    input  mem_addr, instr, instr_valid, pc, busy, instr_count
  );

  modport slave (
    input  fetch_req, instr_ack, pc_ld, pc_rel, pc_target, disp, mem_rdata,
    output mem_addr, instr, instr_valid, pc, busy, instr_count
  );

endinterface

// File: rtl/fetch_pc.sv
// Program counter register. Priority: reset > load > increment.
//   clk, reset : clock, synchronous active-high reset
//   ld, rel    : load request; rel=1 adds sign-extended disp, rel=0 takes target
//   target     : absolute jump target
//   disp       : signed 8-bit displacement
//   inc        : advance pc by one (wraps modulo 2^ADDR_W)
//   pc         : current program counter
module fetch_pc #(
  parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              rel,
  input  logic [ADDR_W-1:0] target,
  input  logic [7:0]        disp,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] disp_ext;

  assign disp_ext = {{(ADDR_W-8){disp[7]}}, disp};

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (ld) begin
      pc_q <= rel ? pc_q + disp_ext : target;
    end else if (inc) begin
      pc_q <= pc_q + ADDR_W'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and instruction register, drives the instruction
// memory read address and hands instructions to the control FSM over a valid/ack handshake.
// Jumps (pc_ld) abort any in-flight fetch.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_unit_if slave (handshake, jump controls, memory port, status)
module fetch_unit #(
  parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned       DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned       MEM_LAT  = 1,  // 1..4
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.slave bus
);

  import cpu_pkg::*;

  localparam logic [1:0] LatInit = 2'(MEM_LAT - 1);

  fetch_state_t      state_q;
  logic [1:0]        lat_cnt_q;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic              busy_q;
  logic [15:0]       count_q;
  logic [ADDR_W-1:0] pc;
  logic              capture;
  logic              ack_ok;

  // A jump in the capture cycle wins: no capture and no increment.
  assign capture = (state_q == StWait) && (lat_cnt_q == 2'd0) && !bus.pc_ld;
  assign ack_ok  = (state_q == StValid) && bus.instr_ack;

  fetch_pc #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_fetch_pc (
    .clk   (clk),
    .reset (reset),
    .ld    (bus.pc_ld),
    .rel   (bus.pc_rel),
    .target(bus.pc_target),
    .disp  (bus.disp),
    .inc   (capture),
    .pc    (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      lat_cnt_q <= 2'd0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      // An ack is retired even when a jump lands in the same cycle.
      if (ack_ok) begin
        count_q <= count_q + 16'd1;
      end
      if (bus.pc_ld) begin
        state_q   <= StIdle;
        lat_cnt_q <= 2'd0;
        valid_q   <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (bus.fetch_req) begin
              state_q   <= StWait;
              lat_cnt_q <= LatInit;
              busy_q    <= 1'b1;
            end
          end
          StWait: begin
            if (lat_cnt_q == 2'd0) begin
              state_q <= StValid;
              instr_q <= bus.mem_rdata;
              valid_q <= 1'b1;
            end else begin
              lat_cnt_q <= lat_cnt_q - 2'd1;
            end
          end
          StValid: begin
            if (bus.instr_ack) begin
              valid_q <= 1'b0;
              if (bus.fetch_req) begin
                // Back-to-back: the PC was already advanced at capture.
                state_q   <= StWait;
                lat_cnt_q <= LatInit;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.mem_addr    = pc;
  assign bus.pc          = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        instr_ack = 1'b0;
  logic        pc_ld = 1'b0;
  logic        pc_rel = 1'b0;
  logic [15:0] pc_target = 16'h0;
  logic [7:0]  disp = 8'h0;

  int checks = 0;
  int errors = 0;

  fetch_unit_if bus1 ();
  fetch_unit_if bus3 ();

  fetch_unit #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  fetch_unit #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;

  assign bus1.fetch_req = fetch_req;
  assign bus1.instr_ack = instr_ack;
  assign bus1.pc_ld     = pc_ld;
  assign bus1.pc_rel    = pc_rel;
  assign bus1.pc_target = pc_target;
  assign bus1.disp      = disp;
  assign bus3.fetch_req = fetch_req;
  assign bus3.instr_ack = instr_ack;
  assign bus3.pc_ld     = pc_ld;
  assign bus3.pc_rel    = pc_rel;
  assign bus3.pc_target = pc_target;
  assign bus3.disp      = disp;

  // Synchronous instruction memory: address sampled at an edge, data MEM_LAT edges later.
  logic [15:0] mem [0:65535];
  logic [15:0] p1;
  logic [15:0] p3 [0:2];

  always @(posedge clk) begin
    p1    <= mem[bus1.mem_addr];
    p3[0] <= mem[bus3.mem_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign bus1.mem_rdata = p1;
  assign bus3.mem_rdata = p3[2];

  // Reference model: a pending fetch remembers its address and edges left until delivery.
  logic [15:0] m_pc [2];
  logic [15:0] m_instr [2];
  logic [15:0] m_count [2];
  logic [15:0] m_faddr [2];
  bit          m_valid [2];
  bit          m_pend [2];
  int          m_left [2];
  int          lat [2] = '{1, 3};

  task automatic start_fetch(int k);
    m_pend[k]  = 1'b1;
    m_left[k]  = lat[k];
    m_faddr[k] = m_pc[k];
  endtask

  task automatic model_step(int k);
    if (reset) begin
      m_pc[k]    = 16'h0000;
      m_instr[k] = 16'h0000;
      m_count[k] = 16'h0000;
      m_valid[k] = 1'b0;
      m_pend[k]  = 1'b0;
      return;
    end
    if (m_valid[k] && instr_ack) m_count[k] = m_count[k] + 16'd1;
    if (pc_ld) begin
      if (pc_rel) m_pc[k] = 16'(int'(m_pc[k]) + int'($signed(disp)));
      else        m_pc[k] = pc_target;
      m_valid[k] = 1'b0;
      m_pend[k]  = 1'b0;
    end else if (m_pend[k]) begin
      m_left[k] = m_left[k] - 1;
      if (m_left[k] == 0) begin
        m_instr[k] = mem[m_faddr[k]];
        m_pc[k]    = m_pc[k] + 16'd1;
        m_valid[k] = 1'b1;
        m_pend[k]  = 1'b0;
      end
    end else if (m_valid[k]) begin
      if (instr_ack) begin
        m_valid[k] = 1'b0;
        if (fetch_req) start_fetch(k);
      end
    end else if (fetch_req) begin
      start_fetch(k);
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("d1_pc",    32'(bus1.pc),          32'(m_pc[0]));
    chk("d1_addr",  32'(bus1.mem_addr),    32'(m_pc[0]));
    chk("d1_instr", 32'(bus1.instr),       32'(m_instr[0]));
    chk("d1_valid", 32'(bus1.instr_valid), 32'(m_valid[0]));
    chk("d1_busy",  32'(bus1.busy),        32'(m_valid[0] || m_pend[0]));
    chk("d1_count", 32'(bus1.instr_count), 32'(m_count[0]));
    chk("d3_pc",    32'(bus3.pc),          32'(m_pc[1]));
    chk("d3_addr",  32'(bus3.mem_addr),    32'(m_pc[1]));
    chk("d3_instr", 32'(bus3.instr),       32'(m_instr[1]));
    chk("d3_valid", 32'(bus3.instr_valid), 32'(m_valid[1]));
    chk("d3_busy",  32'(bus3.busy),        32'(m_valid[1] || m_pend[1]));
    chk("d3_count", 32'(bus3.instr_count), 32'(m_count[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_model();
  endtask

  logic [15:0] got [3];
  int          n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0]     = 16'h0312;
    mem[1]     = 16'h00A1;
    mem[2]     = 16'h00A2;
    mem[3]     = 16'h00A3;
    mem[16'h40] = 16'h4040;

    // Reset values
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_pc",    32'(bus1.pc), 32'h0);
    chk("rst_instr", 32'(bus1.instr), 32'h0);
    chk("rst_valid", 32'(bus1.instr_valid), 32'h0);
    chk("rst_busy",  32'(bus1.busy), 32'h0);
    chk("rst_count", 32'(bus1.instr_count), 32'h0);

    // 1: single fetch, valid one cycle after acceptance
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("t1_wait_valid", 32'(bus1.instr_valid), 32'h0);
    chk("t1_wait_busy",  32'(bus1.busy), 32'h1);
    tick();
    chk("t1_valid", 32'(bus1.instr_valid), 32'h1);
    chk("t1_instr", 32'(bus1.instr), 32'h0312);
    chk("t1_pc",    32'(bus1.pc), 32'h1);
    chk("t1_busy",  32'(bus1.busy), 32'h1);

    // 2: hold without ack, then ack
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_valid", 32'(bus1.instr_valid), 32'h1);
      chk("t2_hold_instr", 32'(bus1.instr), 32'h0312);
      chk("t2_hold_pc",    32'(bus1.pc), 32'h1);
    end
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    chk("t2_count", 32'(bus1.instr_count), 32'h1);
    chk("t2_idle",  32'(bus1.busy), 32'h0);

    // 3: back-to-back ack+req
    n = 0;
    fetch_req = 1'b1;
    for (int c = 0; c < 20 && n < 3; c++) begin
      tick();
      instr_ack = 1'b0;
      chk("t3_busy", 32'(bus1.busy), 32'h1);
      if (bus1.instr_valid) begin
        got[n]    = bus1.instr;
        n++;
        instr_ack = 1'b1;
        fetch_req = (n < 3);
      end
    end
    tick();
    instr_ack = 1'b0;
    fetch_req = 1'b0;
    chk("t3_n",   32'(n), 32'd3);
    chk("t3_i0",  32'(got[0]), 32'h00A1);
    chk("t3_i1",  32'(got[1]), 32'h00A2);
    chk("t3_i2",  32'(got[2]), 32'h00A3);
    chk("t3_pc",  32'(bus1.pc), 32'h4);
    chk("t3_cnt", 32'(bus1.instr_count), 32'h4);

    // 4: absolute jump in the capture cycle
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    pc_ld     = 1'b1;
    pc_rel    = 1'b0;
    pc_target = 16'h0040;
    tick();
    pc_ld = 1'b0;
    chk("t4_pc",    32'(bus1.pc), 32'h40);
    chk("t4_valid", 32'(bus1.instr_valid), 32'h0);
    tick();
    chk("t4_novalid", 32'(bus1.instr_valid), 32'h0);
    chk("t4_pc_hold", 32'(bus1.pc), 32'h40);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    chk("t4_instr", 32'(bus1.instr), 32'h4040);
    chk("t4_pc2",   32'(bus1.pc), 32'h41);
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;

    // 5: relative jump backwards across zero, then wrap forward
    pc_ld     = 1'b1;
    pc_rel    = 1'b0;
    pc_target = 16'h0001;
    tick();
    pc_rel = 1'b1;
    disp   = 8'hFD;
    tick();
    pc_ld  = 1'b0;
    pc_rel = 1'b0;
    chk("t5_rel_pc", 32'(bus1.pc), 32'hFFFE);
    for (int f = 0; f < 2; f++) begin
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      tick();
      chk("t5_valid", 32'(bus1.instr_valid), 32'h1);
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
    end
    chk("t5_wrap_pc", 32'(bus1.pc), 32'h0000);

    // 6: reset in the second WAIT cycle of the MEM_LAT=3 unit
    pc_ld     = 1'b1;
    pc_target = 16'h0010;
    tick();
    pc_ld     = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    chk("t6_wait", 32'(bus3.busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", 32'(bus3.instr_valid), 32'h0);
    chk("t6_pc",    32'(bus3.pc), 32'h0);
    chk("t6_instr", 32'(bus3.instr), 32'h0);
    chk("t6_busy",  32'(bus3.busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_nocap_valid", 32'(bus3.instr_valid), 32'h0);
      chk("t6_nocap_instr", 32'(bus3.instr), 32'h0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 79) == 0);
      fetch_req = 1'($urandom);
      instr_ack = 1'($urandom);
      pc_ld     = ($urandom_range(0, 9) == 0);
      pc_rel    = 1'($urandom);
      pc_target = 16'($urandom);
      disp      = 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
